// File: rtl/b2d_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The requester drives start/bin; the converter returns status and the result.
interface b2d_seq_if #(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 4
);
   logic                  start;
   logic [BIN_W-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  neg;
   logic                  overflow;

   modport master (
      output start, bin,
      input  busy, done, bcd, neg, overflow
   );

   modport slave (
      input  start, bin,
      output busy, done, bcd, neg, overflow
   );
endinterface

// File: rtl/b2d_seq.sv
// Sequential double-dabble converter: one input bit per clock, optional signed
// magnitude mode and a sticky overflow flag when DIGITS is too small.
module b2d_seq #(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 4,
   parameter int SIGNED = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   b2d_seq_if.slave   bus
);
   localparam int CW = $clog2(BIN_W + 1);
   localparam int DW = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

   state_t            state;
   logic [BIN_W-1:0]  shreg;
   logic [DW-1:0]     work;
   logic              work_ovf;
   logic              work_neg;
   logic [CW-1:0]     count;
   logic              busy_q;
   logic              done_q;
   logic [DW-1:0]     bcd_q;
   logic              neg_q;
   logic              ovf_q;

   logic [BIN_W-1:0]  mag;
   logic              is_neg;
   logic [DW-1:0]     adj;
   logic [DW-1:0]     work_next;
   logic              ovf_out;

   // Negating the most negative value wraps to 2^(BIN_W-1), which is its true magnitude.
   always_comb begin
      is_neg = (SIGNED != 0) && bus.bin[BIN_W-1];
      mag    = is_neg ? (~bus.bin + BIN_W'(1)) : bus.bin;
   end

   always_comb begin
      adj = work;
      for (int k = 0; k < DIGITS; k++) begin
         if (work[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
         end
      end
      work_next = {adj[DW-2:0], shreg[BIN_W-1]};
      ovf_out   = adj[DW-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         shreg    <= '0;
         work     <= '0;
         work_ovf <= 1'b0;
         work_neg <= 1'b0;
         count    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bcd_q    <= '0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE, FIN: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  shreg    <= mag;
                  work     <= '0;
                  work_ovf <= 1'b0;
                  work_neg <= is_neg;
                  count    <= CW'(BIN_W);
                  busy_q   <= 1'b1;
                  state    <= SHIFT;
               end else begin
                  state    <= IDLE;
               end
            end
            SHIFT: begin
               shreg    <= shreg << 1;
               work     <= work_next;
               work_ovf <= work_ovf | ovf_out;
               count    <= count - CW'(1);
               // Results load on the final shift so they are already valid during FIN.
               if (count == CW'(1)) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  bcd_q  <= work_next;
                  ovf_q  <= work_ovf | ovf_out;
                  neg_q  <= work_neg;
                  state  <= FIN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.bcd      = bcd_q;
   assign bus.neg      = neg_q;
   assign bus.overflow = ovf_q;
endmodule
